byte_serial_tx: RTL

Parallel-to-serial byte transmitter, the sending end of the team's 8-bit register datapath. It accepts a byte on an 8-bit parallel bus through a Load/Ready handshake. It shifts the byte out LSB-first on a single line, framed with one start bit and one stop bit. Each bit is held for a parameterised number of clock cycles. It sits between a byte-producing register stage and an off-block serial link.

---
 rtl/byte_serial_tx_if.sv | 25 ++
 rtl/byte_serial_tx.sv | 134 +++++++++++++
 2 files changed

// File: rtl/byte_serial_tx_if.sv
// Load/Ready byte handshake plus serial-line outputs of the byte transmitter.
// The master side produces bytes; the slave side is the transmitter itself.
interface byte_serial_tx_if;
  logic [7:0] I;
  logic       Load;
  logic       Ready;
  logic       TxD;
  logic       Done;

  modport master (
    output I,
    output Load,
    input  Ready,
    input  TxD,
    input  Done
  );

  modport slave (
    input  I,
    input  Load,
    output Ready,
    output TxD,
    output Done
  );
endinterface

// File: rtl/byte_serial_tx.sv
// Byte-to-serial transmitter: start bit, 8 data bits LSB-first, stop bit.
// Optional even-parity bit between data and stop when PARITY_EN is defined.
module byte_serial_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  byte_serial_tx_if.slave txIf
);

  localparam int CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef PARITY_EN
    PARITY,
`endif
    STOP
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bitIdx_q, bitIdx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            txd_q, txd_d;
  logic            done_q, done_d;
`ifdef PARITY_EN
  logic            parity_q, parity_d;
`endif
  logic            bitEnd;

  assign bitEnd      = (cnt_q == LastCnt);
  assign txIf.Ready  = (state_q == IDLE);
  assign txIf.TxD    = txd_q;
  assign txIf.Done   = done_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bitIdx_q <= '0;
      cnt_q    <= '0;
      txd_q    <= 1'b1;
      done_q   <= 1'b0;
`ifdef PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitIdx_q <= bitIdx_d;
      cnt_q    <= cnt_d;
      txd_q    <= txd_d;
      done_q   <= done_d;
`ifdef PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // TxD is computed for the state being entered, so the line changes on the same edge as the state.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitIdx_d = bitIdx_q;
    cnt_d    = bitEnd ? '0 : cnt_q + 1'b1;
    txd_d    = txd_q;
    done_d   = 1'b0;
`ifdef PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        txd_d = 1'b1;
        if (txIf.Load) begin
          shift_d = txIf.I;
`ifdef PARITY_EN
          parity_d = ^txIf.I;
`endif
          state_d = START;
          txd_d   = 1'b0;
        end
      end
      START: begin
        if (bitEnd) begin
          state_d  = DATA;
          bitIdx_d = '0;
          txd_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bitEnd) begin
          shift_d  = {1'b0, shift_q[7:1]};
          bitIdx_d = bitIdx_q + 3'd1;
          txd_d    = shift_q[1];
          if (bitIdx_q == 3'd7) begin
`ifdef PARITY_EN
            state_d = PARITY;
            txd_d   = parity_q;
`else
            state_d = STOP;
            txd_d   = 1'b1;
`endif
          end
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        if (bitEnd) begin
          state_d = STOP;
          txd_d   = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bitEnd) begin
          state_d = IDLE;
          done_d  = 1'b1;
          txd_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

endmodule
